// File: rtl/serial_pkg.sv
// Shared state encoding and line-level constants for the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    // Terminal count wraps to 0 so consecutive data bits need no state change.
    always_ff @(posedge clock) begin
        if (reset || clear || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W bits LSB-first, optional parity, stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic ODD_FLIP = (PARITY_ODD != 0);

    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] sr, sr_nx;
    logic [BW-1:0]     bit_cnt;
    logic              par_bit;
    logic              line_nx;
    logic              bit_end;
    logic              timer_clr;

    assign timer_clr = (state_nx != state);

    tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clr),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        unique case (state)
            IDLE:   if (tx_valid) begin
                        state_nx = START;
                        sr_nx    = tx_data;
                    end
            START:  if (bit_end) state_nx = DATA;
            DATA:   if (bit_end) begin
                        sr_nx = sr >> 1;
                        if (bit_cnt == LAST_BIT)
                            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                    end
            PARITY: if (bit_end) state_nx = STOP;
            STOP:   if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Line value is decided from the next state so tx_out can be a plain register.
    always_comb begin
        line_nx = LINE_IDLE;
        unique case (state_nx)
            START:   line_nx = START_BIT;
            DATA:    line_nx = sr_nx[0];
            PARITY:  line_nx = par_bit;
            STOP:    line_nx = STOP_BIT;
            default: line_nx = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tx_out  <= LINE_IDLE;
        end else begin
            state  <= state_nx;
            sr     <= sr_nx;
            tx_out <= line_nx;
            // Parity is fixed by the word captured at acceptance.
            if (state == IDLE && tx_valid)
                par_bit <= (^tx_data) ^ ODD_FLIP;
            if (state_nx != DATA)
                bit_cnt <= '0;
            else if (state == DATA && bit_end)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == STOP) && bit_end;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four parameter variants checked every cycle against a frame-queue model.
module tb_serial_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        chk_on = 1'b0;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Variants: 0 even parity, 1 odd parity, 2 no parity, 3 short word with one-cycle bits.
    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int DW  = (g == 3) ? 5 : 8;
        localparam int CPB = (g == 3) ? 1 : 4;
        localparam int PEN = (g == 2) ? 0 : 1;
        localparam int ODD = (g == 1) ? 1 : 0;

        logic ready, line, busy, done;

        serial_tx #(
            .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN), .PARITY_ODD(ODD)
        ) dut (
            .clock    (clk),
            .reset    (reset),
            .tx_valid (tx_valid),
            .tx_data  (tx_data[DW-1:0]),
            .tx_ready (ready),
            .tx_out   (line),
            .busy     (busy),
            .done     (done)
        );

        // Each accepted word becomes the list of line levels the frame must show, one per cycle.
        bit q[$];
        always @(posedge clk) begin : model
            logic [DW-1:0] w;
            if (reset)
                q.delete();
            else if (q.size() != 0)
                void'(q.pop_front());
            else if (tx_valid) begin
                w = tx_data[DW-1:0];
                for (int k = 0; k < CPB; k++) q.push_back(1'b0);
                for (int b = 0; b < DW; b++)
                    for (int k = 0; k < CPB; k++) q.push_back(w[b]);
                if (PEN != 0)
                    for (int k = 0; k < CPB; k++) q.push_back((^w) ^ (ODD != 0));
                for (int k = 0; k < CPB; k++) q.push_back(1'b1);
            end
        end

        always @(negedge clk) begin
            if (chk_on) begin
                chk($sformatf("g%0d line", g),  line,  (q.size() != 0) ? q[0] : 1'b1);
                chk($sformatf("g%0d ready", g), ready, q.size() == 0);
                chk($sformatf("g%0d busy", g),  busy,  q.size() != 0);
                chk($sformatf("g%0d done", g),  done,  q.size() == 1);
            end
        end
    end

    // Sends one word and checks variant 0 cycle by cycle against the expected frame layout.
    task automatic send_chk(input logic [7:0] w);
        logic e;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = {8'h00, w};
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) @(negedge clk);
            tx_data = 16'($urandom);
            if (c <= 4)       e = 1'b0;
            else if (c <= 36) e = w[(c - 5) / 4];
            else if (c <= 40) e = ^w;
            else              e = 1'b1;
            chk("frame line", g_inst[0].line, e);
            chk("frame done", g_inst[0].done, c == 44);
            chk("frame ready", g_inst[0].ready, c == 45);
            if (c >= 37 && c <= 40)
                chk("odd parity bit", g_inst[1].line, ~(^w));
            chk("no-parity done", g_inst[2].done, c == 40);
        end
        repeat (5) @(negedge clk);
    endtask

    int ndone;

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send_chk(8'hA5);
        send_chk(8'h07);

        // Back-to-back with valid held high.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 16'h0001;
        @(negedge clk);
        tx_data  = 16'h00FF;
        repeat (100) @(negedge clk);
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);

        // Reset during data bit 3 of variant 0, then a clean frame.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 16'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort line", g_inst[0].line, 1'b1);
        chk("abort ready", g_inst[0].ready, 1'b1);
        repeat (3) @(negedge clk);
        send_chk(8'h3C);

        // Valid pulses and data churn while busy must not start another frame.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 16'h0096;
        ndone    = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (g_inst[0].done) ndone++;
            tx_data  = 16'($urandom);
            tx_valid = (c < 40) && ($urandom_range(0, 3) == 0);
        end
        chk("single frame while busy", ndone == 1, 1'b1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            tx_data  = 16'($urandom);
            tx_valid = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        reset    = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
